// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/DM memory port arbiter: FSM states, owner tags,
// the latched request payload and the starvation counter width.
package mem_arb_pkg;

    localparam int MEM_ARB_ADDR_W = 32;
    localparam int MEM_ARB_DATA_W = 32;
    localparam int MEM_ARB_BE_W   = MEM_ARB_DATA_W / 8;
    localparam int STARVE_CNT_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    typedef struct packed {
        logic                      we;
        logic [MEM_ARB_ADDR_W-1:0] addr;
        logic [MEM_ARB_DATA_W-1:0] wdata;
        logic [MEM_ARB_BE_W-1:0]   be;
    } mem_req_t;

endpackage

// File: rtl/mem_arb_priority.sv
// Winner select between IF and DM: DM has priority, IF is forced through once
// STARVE_LIMIT consecutive DM grants have happened while IF was waiting.
module mem_arb_priority
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_if_valid,
    input  logic i_dm_valid,
    input  logic i_idle,
    output logic o_grant_if,
    output logic o_grant_dm
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

    logic [STARVE_CNT_W-1:0] starve_q;
    logic [STARVE_CNT_W-1:0] starve_d;
    logic                    starved_s;

    // Grant decision and next starvation count.
    always_comb begin
        starved_s  = (starve_q == LIMIT);
        o_grant_if = i_idle && i_if_valid && (!i_dm_valid || starved_s);
        o_grant_dm = i_idle && i_dm_valid && !(i_if_valid && starved_s);
        starve_d   = starve_q;
        if (!i_if_valid || o_grant_if) begin
            starve_d = {STARVE_CNT_W{1'b0}};
        end else if (o_grant_dm && !starved_s) begin
            starve_d = starve_q + {{(STARVE_CNT_W-1){1'b0}}, 1'b1};
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            starve_q <= {STARVE_CNT_W{1'b0}};
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data load/store, one
// transaction at a time. Define MEM_ARB_TIMEOUT_EN to add a response watchdog.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = MEM_ARB_DATA_W,
    parameter int ADDR_WIDTH     = MEM_ARB_ADDR_W,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_if_req_valid,
    input  logic [ADDR_WIDTH-1:0]   i_if_req_addr,
    output logic                    o_if_req_ready,
    output logic                    o_if_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_if_rsp_data,
    output logic                    o_if_rsp_err,
    input  logic                    i_dm_req_valid,
    input  logic                    i_dm_req_we,
    input  logic [ADDR_WIDTH-1:0]   i_dm_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_dm_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] i_dm_req_be,
    output logic                    o_dm_req_ready,
    output logic                    o_dm_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_dm_rsp_rdata,
    output logic                    o_dm_rsp_err,
    output logic                    o_mem_req_valid,
    input  logic                    i_mem_req_ready,
    output logic                    o_mem_req_we,
    output logic [ADDR_WIDTH-1:0]   o_mem_req_addr,
    output logic [DATA_WIDTH-1:0]   o_mem_req_wdata,
    output logic [DATA_WIDTH/8-1:0] o_mem_req_be,
    input  logic                    i_mem_rsp_valid,
    input  logic [DATA_WIDTH-1:0]   i_mem_rsp_rdata,
    output logic                    o_stall
);

    state_e                  state_q;
    owner_e                  owner_q;
    mem_req_t                req_q;
    logic                    mem_req_valid_q;
    logic                    if_rsp_valid_q;
    logic                    dm_rsp_valid_q;
    logic [DATA_WIDTH-1:0]   if_rsp_data_q;
    logic [DATA_WIDTH-1:0]   dm_rsp_rdata_q;
    logic                    idle_s;
    logic                    grant_if_s;
    logic                    grant_dm_s;
    logic                    stall_s;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q;
    logic             tmo_expire_s;
    logic             if_rsp_err_q;
    logic             dm_rsp_err_q;
    assign tmo_expire_s = (tmo_q == TMO_LAST);
    assign o_if_rsp_err = if_rsp_err_q;
    assign o_dm_rsp_err = dm_rsp_err_q;
`else
    assign o_if_rsp_err = 1'b0;
    assign o_dm_rsp_err = 1'b0;
`endif

    assign idle_s = (state_q == ST_IDLE) && !i_reset;

    mem_arb_priority #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_priority (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_if_valid (i_if_req_valid),
        .i_dm_valid (i_dm_req_valid),
        .i_idle     (idle_s),
        .o_grant_if (grant_if_s),
        .o_grant_dm (grant_dm_s)
    );

    // Ready and stall follow the live request lines, so they stay combinational.
    always_comb begin
        o_if_req_ready = grant_if_s;
        o_dm_req_ready = grant_dm_s;
        stall_s = (i_if_req_valid && !grant_if_s) ||
                  (i_dm_req_valid && !grant_dm_s) ||
                  (state_q != ST_IDLE);
        o_stall = stall_s && !i_reset;
    end

    // Transaction FSM with registered memory payload and response pulses.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q         <= ST_IDLE;
            owner_q         <= OWN_NONE;
            req_q           <= '0;
            mem_req_valid_q <= 1'b0;
            if_rsp_valid_q  <= 1'b0;
            dm_rsp_valid_q  <= 1'b0;
            if_rsp_data_q   <= {DATA_WIDTH{1'b0}};
            dm_rsp_rdata_q  <= {DATA_WIDTH{1'b0}};
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_q           <= {TMO_W{1'b0}};
            if_rsp_err_q    <= 1'b0;
            dm_rsp_err_q    <= 1'b0;
`endif
        end else begin
            if_rsp_valid_q <= 1'b0;
            dm_rsp_valid_q <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            if_rsp_err_q   <= 1'b0;
            dm_rsp_err_q   <= 1'b0;
            tmo_q          <= (state_q == ST_IDLE) ? {TMO_W{1'b0}} : tmo_q + {{(TMO_W-1){1'b0}}, 1'b1};
`endif
            case (state_q)
                ST_IDLE: begin
                    if (grant_dm_s) begin
                        req_q.we        <= i_dm_req_we;
                        req_q.addr      <= MEM_ARB_ADDR_W'(i_dm_req_addr);
                        req_q.wdata     <= MEM_ARB_DATA_W'(i_dm_req_wdata);
                        req_q.be        <= MEM_ARB_BE_W'(i_dm_req_be);
                        owner_q         <= OWN_DM;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= ST_REQ;
                    end else if (grant_if_s) begin
                        req_q.we        <= 1'b0;
                        req_q.addr      <= MEM_ARB_ADDR_W'(i_if_req_addr);
                        req_q.wdata     <= {MEM_ARB_DATA_W{1'b0}};
                        req_q.be        <= {MEM_ARB_BE_W{1'b1}};
                        owner_q         <= OWN_IF;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (i_mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= ST_RESP;
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (tmo_expire_s) begin
                        mem_req_valid_q <= 1'b0;
                        state_q         <= ST_IDLE;
                        owner_q         <= OWN_NONE;
                        if_rsp_valid_q  <= (owner_q == OWN_IF);
                        if_rsp_err_q    <= (owner_q == OWN_IF);
                        dm_rsp_valid_q  <= (owner_q == OWN_DM);
                        dm_rsp_err_q    <= (owner_q == OWN_DM);
                        if_rsp_data_q   <= {DATA_WIDTH{1'b0}};
                        dm_rsp_rdata_q  <= {DATA_WIDTH{1'b0}};
                    end
`endif
                end
                ST_RESP: begin
                    if (i_mem_rsp_valid) begin
                        state_q <= ST_IDLE;
                        owner_q <= OWN_NONE;
                        if (owner_q == OWN_IF) begin
                            if_rsp_valid_q <= 1'b1;
                            if_rsp_data_q  <= i_mem_rsp_rdata;
                        end else if (owner_q == OWN_DM) begin
                            dm_rsp_valid_q <= 1'b1;
                            // Store acks carry no data.
                            dm_rsp_rdata_q <= req_q.we ? {DATA_WIDTH{1'b0}} : i_mem_rsp_rdata;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (tmo_expire_s) begin
                        state_q        <= ST_IDLE;
                        owner_q        <= OWN_NONE;
                        if_rsp_valid_q <= (owner_q == OWN_IF);
                        if_rsp_err_q   <= (owner_q == OWN_IF);
                        dm_rsp_valid_q <= (owner_q == OWN_DM);
                        dm_rsp_err_q   <= (owner_q == OWN_DM);
                        if_rsp_data_q  <= {DATA_WIDTH{1'b0}};
                        dm_rsp_rdata_q <= {DATA_WIDTH{1'b0}};
                    end
`endif
                end
                default: begin
                    state_q         <= ST_IDLE;
                    owner_q         <= OWN_NONE;
                    mem_req_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_req_valid = mem_req_valid_q;
    assign o_mem_req_we    = req_q.we;
    assign o_mem_req_addr  = ADDR_WIDTH'(req_q.addr);
    assign o_mem_req_wdata = DATA_WIDTH'(req_q.wdata);
    assign o_mem_req_be    = (DATA_WIDTH/8)'(req_q.be);
    assign o_if_rsp_valid  = if_rsp_valid_q;
    assign o_if_rsp_data   = if_rsp_data_q;
    assign o_dm_rsp_valid  = dm_rsp_valid_q;
    assign o_dm_rsp_rdata  = dm_rsp_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single shared memory port between instruction fetch (IF) and data load/store (DM) in the RISC-V core.
- One transaction outstanding at a time; data priority with an IF anti-starvation limit.
- Drives a stall to the pipeline while either requester waits.
- Sits between the fetch/LSU stages and the unified memory.

Parameters:
DATA_WIDTH, 32, data bus width
ADDR_WIDTH, 32, address width
STARVE_LIMIT, 4, consecutive DM grants while IF pending before IF is forced; range 1..15
TIMEOUT_CYCLES, 64, watchdog limit; used only with MEM_ARB_TIMEOUT_EN

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_if_req_valid  in  1  IF read request
i_if_req_addr  in  ADDR_WIDTH  IF address
o_if_req_ready  out  1  IF request accepted
o_if_rsp_valid  out  1  IF response pulse
o_if_rsp_data  out  DATA_WIDTH  instruction word
o_if_rsp_err  out  1  IF timeout error
i_dm_req_valid  in  1  DM request
i_dm_req_we  in  1  1=store
i_dm_req_addr  in  ADDR_WIDTH  DM address
i_dm_req_wdata  in  DATA_WIDTH  store data
i_dm_req_be  in  DATA_WIDTH/8  byte enables
o_dm_req_ready  out  1  DM request accepted
o_dm_rsp_valid  out  1  DM response pulse (loads and stores)
o_dm_rsp_rdata  out  DATA_WIDTH  load data
o_dm_rsp_err  out  1  DM timeout error
o_mem_req_valid  out  1  memory request
i_mem_req_ready  in  1  memory accepts request
o_mem_req_we / o_mem_req_addr / o_mem_req_wdata / o_mem_req_be  out  1/ADDR_WIDTH/DATA_WIDTH/DATA_WIDTH/8  registered payload
i_mem_rsp_valid  in  1  memory response (reads and write acks)
i_mem_rsp_rdata  in  DATA_WIDTH  read data
o_stall  out  1  pipeline stall

Behaviour:
- Reset: FSM=IDLE, owner=NONE, starve_cnt=0.
- Reset values: all o_*_valid, o_*_ready, o_*_err, o_mem_* and o_stall are 0; data outputs are 0.
- Handshake: requesters hold valid and payload stable until ready. A transfer occurs when valid&&ready.
- FSM states:
  - IDLE: o_*_req_ready is combinational, asserted only for the winner, only in IDLE. On handshake, latch payload and owner; go to REQ.
  - REQ: o_mem_req_valid=1 from registers. On i_mem_req_ready, go to RESP.
  - RESP: on i_mem_rsp_valid, go to IDLE. Next cycle, pulse owner's rsp_valid for 1 cycle with registered rdata; the other requester's rsp_valid stays 0.
- Latency:
  - Accept at cycle 0; o_mem_req_valid at cycle 1.
  - With zero-wait memory (ready at cycle 1, rsp at cycle 2): rsp_valid at cycle 3.
  - Next grant is possible in cycle 3, concurrent with the response pulse.
- Arbitration (IDLE, both valid):
  - DM wins unless starve_cnt==STARVE_LIMIT, in which case IF wins.
  - starve_cnt increments on each DM grant while i_if_req_valid=1; saturates at STARVE_LIMIT.
  - starve_cnt clears on an IF grant or any cycle with i_if_req_valid=0.
  - A single valid requester always wins.
- Write response: stores complete on i_mem_rsp_valid. o_dm_rsp_valid pulses with rdata=0.
- o_stall = (i_if_req_valid && !(handshake on IF)) || (i_dm_req_valid && !(handshake on DM)) || (FSM!=IDLE && owner's response not yet delivered).
- Spurious i_mem_rsp_valid outside RESP is ignored. i_mem_req_ready outside REQ is ignored.
- Reset in any state: returns to IDLE next edge. The in-flight transaction is dropped and no response is delivered.

Optional Feature:
MEM_ARB_TIMEOUT_EN
- Defined:
  - A counter clears on entry to REQ and increments each cycle in REQ/RESP.
  - When it reaches TIMEOUT_CYCLES, FSM returns to IDLE.
  - Owner receives a 1-cycle rsp_valid with rsp_err=1 and data=0.
  - A late i_mem_rsp_valid is then ignored.
- Undefined: no counter; o_if_rsp_err and o_dm_rsp_err are tied 0; the FSM waits indefinitely.

Decomposition:
- mem_arb_pkg:
  - state enum (IDLE, REQ, RESP)
  - owner enum (NONE, IF, DM)
  - mem_req_t struct (we, addr, wdata, be)
  - starve counter width localparam (4)
- Sub-module mem_arb_priority: starvation counter plus winner select. Inputs: both valids, idle. Outputs: grant_if, grant_dm.

Test Plan:
- IF-only read of 0x100, memory ready at cycle 1, rsp 0xDEADBEEF at cycle 2 -> o_if_rsp_valid at cycle 3 with 0xDEADBEEF; o_dm_rsp_valid stays 0.
- IF and DM both valid continuously, STARVE_LIMIT=4 -> grant order DM,DM,DM,DM,IF,DM...; o_stall high for IF throughout its wait.
- DM store 0x12345678 to 0x200, be=4'b0011, memory ready held low 3 cycles -> o_mem_req_valid and payload stable 4 cycles; o_dm_rsp_valid after ack with rdata=0.
- i_reset asserted while in RESP -> next cycle IDLE, all outputs 0; a subsequent i_mem_rsp_valid produces no rsp_valid.
- Spurious i_mem_rsp_valid in IDLE -> no rsp pulse, FSM stays IDLE.
- With MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, memory never responds to a DM load -> after 8 cycles o_dm_rsp_valid=1, o_dm_rsp_err=1, rdata=0; FSM back in IDLE.
